wam_mole_gen: RTL

//  Mole generator: decides which holes show a mole and for how long. Feeds mole[7:0]
//  to the tap/hit scoring path and takes back per-hole whack pulses from it.

---
 rtl/wam_mole_gen_pkg.sv | 23 ++
 rtl/wam_mole_gen_hole.sv | 76 +++++++
 rtl/wam_mole_gen.sv | 102 ++++++++++
 3 files changed

// File: rtl/wam_mole_gen_pkg.sv
// Shared definitions for the whack-a-mole generator: hole state encoding,
// LFSR feedback and the level-scaled interval helper.
package wam_mole_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    COOL = 2'd2
  } hole_state_t;

  // Fibonacci taps 16,14,13,11 (bits 15,13,12,10).
  function automatic logic lfsr_feedback(input logic [15:0] s);
    return s[15] ^ s[13] ^ s[12] ^ s[10];
  endfunction

  // Interval shortened by level, never below one tick.
  function automatic int unsigned scale_ticks(input int unsigned base, input logic [1:0] lvl);
    int unsigned s;
    s = base >> lvl;
    return (s == 0) ? 1 : s;
  endfunction

endpackage

// File: rtl/wam_mole_gen_hole.sv
// One hole: IDLE -> UP -> COOL -> IDLE, with a shared life/cool down-counter
// and a registered miss pulse when the mole retreats unwhacked.
module wam_mole_gen_hole
  import wam_mole_gen_pkg::*;
#(
  parameter int CW         = 10,
  parameter int COOL_TICKS = 200
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          en,
  input  logic          tick,
  input  logic          sel,
  input  logic          whack,
  input  logic [CW-1:0] life_load,
  output logic          up,
  output logic          idle,
  output logic          miss
);

  localparam logic [CW-1:0] COOL_LOAD = CW'(COOL_TICKS);

  hole_state_t   state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          miss_nxt;

  // NOTE: every variable gets its default before the case, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    miss_nxt  = 1'b0;
    unique case (state)
      IDLE: if (sel) begin
        state_nxt = UP;
        cnt_nxt   = life_load;
      end
      UP: begin
        // A whack in the expiry cycle wins, so no miss is reported.
        if (en && whack) begin
          state_nxt = COOL;
          cnt_nxt   = COOL_LOAD;
        end else if (tick) begin
          if (cnt == CW'(1)) begin
            state_nxt = COOL;
            cnt_nxt   = COOL_LOAD;
            miss_nxt  = 1'b1;
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
      end
      COOL: if (tick) begin
        if (cnt == CW'(1)) state_nxt = IDLE;
        else               cnt_nxt   = cnt - 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= IDLE;
      cnt   <= '0;
      miss  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      miss  <= miss_nxt;
    end
  end

  assign up   = (state == UP);
  assign idle = (state == IDLE);

endmodule

// File: rtl/wam_mole_gen.sv
// Mole generator: game-tick prescaler, free-running LFSR, spawn timer,
// rotating free-hole search and the per-hole state machines.
module wam_mole_gen
  import wam_mole_gen_pkg::*;
#(
  parameter int          N_HOLES     = 8,
  parameter int          TICK_DIV    = 100000,
  parameter int          SPAWN_TICKS = 700,
  parameter int          LIFE_TICKS  = 1000,
  parameter int          COOL_TICKS  = 200,
  parameter int          MAX_UP      = 3,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               en,
  input  logic [1:0]         level,
  input  logic [N_HOLES-1:0] whack,
  output logic [N_HOLES-1:0] mole,
  output logic               spawn,
  output logic [N_HOLES-1:0] miss,
  output logic [3:0]         up_cnt
);

  localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TW   = $clog2(SPAWN_TICKS + 1);
  localparam int CMAX = (LIFE_TICKS > COOL_TICKS) ? LIFE_TICKS : COOL_TICKS;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int SW   = (N_HOLES > 1) ? $clog2(N_HOLES) : 1;

  logic [PW-1:0]      pre;
  logic               tick;
  logic [15:0]        lfsr;
  logic [TW-1:0]      timer;
  logic               attempt;
  logic [N_HOLES-1:0] idle;
  logic [N_HOLES-1:0] pick;
  logic               found;
  logic [SW-1:0]      idx;
  logic [CW-1:0]      life_load;

  assign tick = en && (pre == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge clr) begin
    if (!clr)    pre <= '0;
    else if (en) pre <= tick ? '0 : pre + 1'b1;
  end

  // The LFSR keeps running while the game is frozen.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) lfsr <= LFSR_SEED;
    else      lfsr <= {lfsr[14:0], lfsr_feedback(lfsr)};
  end

  // ">=" keeps attempts coming after level shortens the interval mid-count.
  assign attempt = tick && ((32'(timer) + 32'd1) >= scale_ticks(SPAWN_TICKS, level));

  always_ff @(posedge clk or negedge clr) begin
    if (!clr)      timer <= '0;
    else if (tick) timer <= attempt ? '0 : timer + 1'b1;
  end

  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N_HOLES; k++) begin
      idx = SW'((32'(lfsr[SW-1:0]) + k) % N_HOLES);
      if (!found && idle[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  assign spawn     = attempt && (up_cnt < 4'(MAX_UP)) && found;
  assign life_load = CW'(scale_ticks(LIFE_TICKS, level));

  for (genvar g = 0; g < N_HOLES; g++) begin : g_hole
    wam_mole_gen_hole #(
      .CW         (CW),
      .COOL_TICKS (COOL_TICKS)
    ) u_hole (
      .clk       (clk),
      .clr       (clr),
      .en        (en),
      .tick      (tick),
      .sel       (spawn && pick[g]),
      .whack     (whack[g]),
      .life_load (life_load),
      .up        (mole[g]),
      .idle      (idle[g]),
      .miss      (miss[g])
    );
  end

  always_comb begin
    up_cnt = '0;
    for (int i = 0; i < N_HOLES; i++) up_cnt = up_cnt + 4'(mole[i]);
  end

endmodule
